// File: rtl/mem_responder_if.sv
// Request/response bus between the multicycle datapath and the memory responder.
interface mem_responder_if;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed memory responder: one request at a time, WAIT_CYCLES wait states,
// then the access, then a single-cycle response pulse.
module mem_responder #(
  parameter int unsigned ADDR_WORDS  = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic            clock,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam int unsigned IdxW = (ADDR_WORDS > 1) ? $clog2(ADDR_WORDS) : 1;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [3:0]      cnt_q, cnt_d;
  // Only the word index is kept; out-of-range upper bits are folded into err at acceptance.
  logic [IdxW-1:0] addr_q, addr_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            write_q, write_d;
  logic            err_q, err_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            rerr_q, rerr_d;

  // Storage starts at zero and is deliberately untouched by reset.
  logic [31:0]     mem_q [ADDR_WORDS] = '{default: '0};

  logic            req_err;
  logic            mem_we;

  // Request decode and array write enable.
  always_comb begin
    req_err = (bus.req_addr[1:0] != 2'b00) ||
              ({2'b00, bus.req_addr[31:2]} >= 32'(ADDR_WORDS));
    mem_we  = (state_q == StBusy) && (cnt_q == 4'd0) && write_q && !err_q;
  end

  // Next-state logic for the IDLE -> BUSY -> RESP handshake.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr[IdxW+1:2];
          wdata_d = bus.req_wdata;
          write_d = bus.req_write;
          err_d   = req_err;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = StBusy;
        end
      end
      StBusy: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          rdata_d = (!write_q && !err_q) ? mem_q[addr_q] : 32'h0;
          rerr_d  = err_q;
          state_d = StResp;
        end
      end
      StResp: begin
        rdata_d = 32'h0;
        rerr_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Control and request registers; async reset aborts any request in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0;
      write_q <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'h0;
      rerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      rerr_q  <= rerr_d;
    end
  end

  // Storage write on the access edge of a good store.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = (state_q == StResp);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = rerr_q;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two builds (WAIT_CYCLES=2 and 0) against an array model.
module tb_mem_responder;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  mem_responder_if bus2 ();
  mem_responder_if bus0 ();

  mem_responder #(.ADDR_WORDS(64), .WAIT_CYCLES(2)) dut2 (
    .clock(clock), .reset(reset), .bus(bus2)
  );
  mem_responder #(.ADDR_WORDS(64), .WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .bus(bus0)
  );

  int tests = 0;
  int fails = 0;
  logic [31:0] model2 [64];
  logic [31:0] model0 [64];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ready(input bit w0);
    return w0 ? bus0.req_ready : bus2.req_ready;
  endfunction
  function automatic logic get_rvalid(input bit w0);
    return w0 ? bus0.resp_valid : bus2.resp_valid;
  endfunction
  function automatic logic [31:0] get_rdata(input bit w0);
    return w0 ? bus0.resp_rdata : bus2.resp_rdata;
  endfunction
  function automatic logic get_rerr(input bit w0);
    return w0 ? bus0.resp_err : bus2.resp_err;
  endfunction

  task automatic drive(input bit w0, input logic v, input logic wr, input logic [31:0] a,
                       input logic [31:0] d);
    if (w0) begin
      bus0.req_valid = v; bus0.req_write = wr; bus0.req_addr = a; bus0.req_wdata = d;
    end else begin
      bus2.req_valid = v; bus2.req_write = wr; bus2.req_addr = a; bus2.req_wdata = d;
    end
  endtask

  // One complete request with latency, data and pulse-width checks against the model.
  task automatic xact(input bit w0, input logic wr, input logic [31:0] a, input logic [31:0] d,
                      input string tag);
    int          w;
    int          k;
    bit          found;
    logic        exp_err;
    logic [31:0] exp_rd;
    w       = w0 ? 0 : 2;
    exp_err = (a % 4 != 0) || ((a / 4) >= 64);
    exp_rd  = 32'h0;
    @(negedge clock);
    drive(w0, 1'b1, wr, a, d);
    k = 0;
    while (!get_ready(w0) && k < 20) begin
      @(negedge clock);
      k++;
    end
    check({tag, " ready"}, 32'(get_ready(w0)), 32'd1);
    @(posedge clock);
    #1 drive(w0, 1'b0, 1'($urandom), $urandom, $urandom);
    if (!exp_err) begin
      if (wr) begin
        if (w0) model0[a / 4] = d; else model2[a / 4] = d;
      end else begin
        exp_rd = w0 ? model0[a / 4] : model2[a / 4];
      end
    end
    found = 1'b0;
    k = 0;
    while (!found && k < 20) begin
      @(negedge clock);
      k++;
      if (get_rvalid(w0)) found = 1'b1;
      else check({tag, " busy ready"}, 32'(get_ready(w0)), 32'd0);
    end
    check({tag, " latency"}, 32'(k), 32'(w + 2));
    check({tag, " rdata"}, get_rdata(w0), exp_rd);
    check({tag, " err"}, 32'(get_rerr(w0)), 32'(exp_err));
    @(negedge clock);
    check({tag, " pulse end"}, 32'(get_rvalid(w0)), 32'd0);
    check({tag, " rdata clr"}, get_rdata(w0), 32'h0);
    check({tag, " err clr"}, 32'(get_rerr(w0)), 32'd0);
    check({tag, " idle ready"}, 32'(get_ready(w0)), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int          rdy_cyc [3];
    int          rsp_cyc [3];
    logic [31:0] rsp_dat [3];
    int          nacc;
    int          nrsp;
    logic [31:0] a;
    int          sel;

    for (int i = 0; i < 64; i++) begin
      model2[i] = 32'h0;
      model0[i] = 32'h0;
    end
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    #12;
    for (int j = 0; j < 2; j++) begin
      check("reset ready", 32'(get_ready(j[0])), 32'd1);
      check("reset rvalid", 32'(get_rvalid(j[0])), 32'd0);
      check("reset rdata", get_rdata(j[0]), 32'h0);
      check("reset err", 32'(get_rerr(j[0])), 32'd0);
    end
    @(negedge clock);
    reset = 1'b0;

    // Store then load.
    xact(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, "st 0x10");
    xact(1'b0, 1'b0, 32'h10, 32'h0, "ld 0x10");
    check("ld 0x10 model", model2[4], 32'hDEADBEEF);

    // Misaligned and out of range; neither may disturb storage.
    xact(1'b0, 1'b0, 32'h6, 32'h0, "ld misaligned");
    xact(1'b0, 1'b0, 32'h4, 32'h0, "ld word1");
    xact(1'b0, 1'b1, 32'h100, 32'h1234, "st out of range");
    xact(1'b0, 1'b0, 32'h0, 32'h0, "ld word0 no alias");

    // Reset while BUSY with counter=1: request aborted, no write, no response.
    @(negedge clock);
    drive(1'b0, 1'b1, 1'b1, 32'h20, 32'hCAFEF00D);
    @(posedge clock);
    #1 drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clock);
    #1 reset = 1'b1;
    #1;
    check("abort ready", 32'(bus2.req_ready), 32'd1);
    check("abort rvalid", 32'(bus2.resp_valid), 32'd0);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clock);
      check("abort no resp", 32'(bus2.resp_valid), 32'd0);
    end
    xact(1'b0, 1'b0, 32'h20, 32'h0, "ld 0x20 after abort");

    // Back-to-back loads with req_valid held high.
    xact(1'b0, 1'b1, 32'h0, $urandom, "preload 0");
    xact(1'b0, 1'b1, 32'h4, $urandom, "preload 1");
    xact(1'b0, 1'b1, 32'h8, $urandom, "preload 2");
    @(negedge clock);
    drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    nacc = 0;
    nrsp = 0;
    for (int c = 0; c < 30; c++) begin
      if (bus2.resp_valid && nrsp < 3) begin
        rsp_cyc[nrsp] = c;
        rsp_dat[nrsp] = bus2.resp_rdata;
        nrsp++;
      end
      if (bus2.req_ready && bus2.req_valid && nacc < 3) begin
        bus2.req_addr = 32'(nacc * 4);
        rdy_cyc[nacc] = c;
        nacc++;
      end else if (nacc >= 3) begin
        bus2.req_valid = 1'b0;
      end
      @(negedge clock);
    end
    check("b2b accepts", 32'(nacc), 32'd3);
    check("b2b responses", 32'(nrsp), 32'd3);
    if (nacc == 3 && nrsp == 3) begin
      check("b2b first latency", 32'(rsp_cyc[0] - rdy_cyc[0]), 32'd4);
      for (int i = 1; i < 3; i++) begin
        check("b2b ready spacing", 32'(rdy_cyc[i] - rdy_cyc[i-1]), 32'd5);
        check("b2b resp spacing", 32'(rsp_cyc[i] - rsp_cyc[i-1]), 32'd5);
      end
      for (int i = 0; i < 3; i++) check("b2b data", rsp_dat[i], model2[i]);
    end

    // Zero-wait build.
    xact(1'b1, 1'b1, 32'h3C, 32'h0F0F0F0F, "w0 st 0x3c");
    xact(1'b1, 1'b0, 32'h3C, 32'h0, "w0 ld 0x3c");
    check("w0 ld model", model0[15], 32'h0F0F0F0F);

    // Randomized traffic on both builds.
    for (int n = 0; n < 45; n++) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 7) a = 32'($urandom_range(0, 63)) * 4;
      else if (sel == 7) a = ($urandom & 32'hFC) | 32'($urandom_range(1, 3));
      else a = ($urandom | 32'h100) & 32'hFFFF_FFFC;
      xact(n >= 30, 1'($urandom), a, $urandom, n >= 30 ? "rand w0" : "rand w2");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
